// File: rtl/mem_seq_pkg.sv
// Shared types and default widths for the memory fill/dump sequencer.
// CLEAR state exists only when MEM_SEQUENCER_CLEAR_EN is defined.
package mem_seq_pkg;

  localparam int unsigned MS_DEFAULT_ADDR_WIDTH = 6;
  localparam int unsigned MS_DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DUMP  = 2'd2
`ifdef MEM_SEQUENCER_CLEAR_EN
    ,
    CLEAR = 2'd3
`endif
  } mem_seq_state_t;

endpackage

// File: rtl/mem_sequencer.sv
// Sequencer that streams words into (FILL) or out of (DUMP) an external single-port RAM.
// Optional feature: define MEM_SEQUENCER_CLEAR_EN to add a full-depth zeroing CLEAR sequence.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MS_DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MS_DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_fill,
  input  logic                  start_dump,
  input  logic                  start_clear,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  mem_seq_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_WIDTH-1:0]  count_clamped;
  logic                  done_q, done_d;
  logic                  step;

`ifndef MEM_SEQUENCER_CLEAR_EN
  logic unused_start_clear;
  assign unused_start_clear = start_clear;
`endif

  assign count_clamped = (count > DEPTH) ? DEPTH : count;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  // Asynchronous RAM read: ptr only moves on a handshake, so data holds while stalled.
  assign out_data      = ram_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Next-state and RAM/stream strobes; step marks a word transferred this cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    step      = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = ptr_q;
    ram_din   = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
`ifdef MEM_SEQUENCER_CLEAR_EN
        if (start_clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
          rem_d   = DEPTH;
        end else
`endif
        if (start_fill || start_dump) begin
          ptr_d = '0;
          rem_d = count_clamped;
          if (count_clamped == '0) done_d = 1'b1;
          else if (start_fill)     state_d = FILL;
          else                     state_d = DUMP;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_we  = 1'b1;
          ram_din = in_data;
          step    = 1'b1;
        end
      end
      DUMP: begin
        out_valid = 1'b1;
        step      = out_ready;
      end
`ifdef MEM_SEQUENCER_CLEAR_EN
      CLEAR: begin
        ram_we = 1'b1;
        step   = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Termination follows rem so a full-depth run ends even though ptr wraps to 0.
    if (step) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      rem_d = rem_q - CNT_WIDTH'(1);
      if (rem_q == CNT_WIDTH'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (reset) begin
      ram_we    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized scoreboard bench for mem_sequencer; the RAM model sits beside the DUT here.
// Exercises the CLEAR sequence when MEM_SEQUENCER_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_mem_sequencer;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_fill = 1'b0, start_dump = 1'b0, start_clear = 1'b0;
  logic [CW-1:0] count = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_din, ram_dout;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } xfer_t;

  logic [DW-1:0] ram   [DEPTH];
  logic [DW-1:0] model [DEPTH];
  xfer_t         wq[$];
  xfer_t         dq[$];
  int            exp_done = 0;
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  mem_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .start_fill(start_fill), .start_dump(start_dump), .start_clear(start_clear),
    .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM: synchronous write, asynchronous read.
  always @(posedge clk) if (ram_we) ram[ram_adr] <= ram_din;
  assign ram_dout = ram[ram_adr];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write, every presented dump word and every done pulse is matched to the scoreboard.
  bit done_prev = 1'b0;
  always @(negedge clk) begin
    xfer_t e;
    if (ram_we) begin
      if (wq.size() == 0) check(1'b0, "unexpected_write", 64'(ram_adr), 64'(0));
      else begin
        e = wq.pop_front();
        check(ram_adr == e.adr, "write_adr", 64'(ram_adr), 64'(e.adr));
        check(ram_din == e.data, "write_data", 64'(ram_din), 64'(e.data));
      end
    end
    if (out_valid) begin
      if (dq.size() == 0) check(1'b0, "unexpected_out_valid", 64'(out_data), 64'(0));
      else begin
        e = dq[0];
        check(ram_adr == e.adr, "dump_adr", 64'(ram_adr), 64'(e.adr));
        check(out_data == e.data, "dump_data", 64'(out_data), 64'(e.data));
        if (out_ready) void'(dq.pop_front());
      end
    end
    if (done) begin
      check(exp_done > 0, "done_expected", 64'(exp_done), 64'(1));
      check(wq.size() == 0 && dq.size() == 0, "done_after_last",
            64'(wq.size() + dq.size()), 64'(0));
      check(!busy, "done_busy", 64'(busy), 64'(0));
      check(!done_prev, "done_one_cycle", 64'(done_prev), 64'(0));
      if (exp_done > 0) exp_done--;
    end
    done_prev = done;
  end

  task automatic wait_done();
    @(negedge clk); #1;
    check(exp_done == 0, "done_pulse", 64'(exp_done), 64'(0));
    check(!busy, "idle_at_done", 64'(busy), 64'(0));
    exp_done = 0;
    @(negedge clk); #1;
    check(!busy && !out_valid && !in_ready, "quiet_after_done",
          64'({busy, out_valid, in_ready}), 64'(0));
  endtask

  // Fill: seq_data gives 0xA0+i, otherwise random words.
  task automatic run_fill(input int cnt, input bit seq_data, input bit rnd_valid,
                          input bit both_start, input bit dump_mid);
    int n, idx, guard;
    bit hs;
    logic [DW-1:0] d[$];
    xfer_t w;
    n = (cnt > int'(DEPTH)) ? int'(DEPTH) : cnt;
    for (int i = 0; i < n; i++) begin
      d.push_back(seq_data ? DW'(32'hA0 + i) : DW'($urandom));
      w.adr  = AW'(i % int'(DEPTH));
      w.data = d[i];
      wq.push_back(w);
      model[i % int'(DEPTH)] = d[i];
    end
    exp_done++;
    @(posedge clk); #1;
    start_fill = 1'b1; start_dump = both_start; count = CW'(cnt);
    @(posedge clk); #1;
    start_fill = 1'b0; start_dump = 1'b0;
    idx = 0; guard = 0;
    in_valid = (n > 0) && (!rnd_valid || $urandom_range(0, 2) != 0);
    in_data  = (n > 0) ? d[0] : '0;
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      if (both_start && guard == 0)
        check(in_ready && !out_valid, "fill_wins", 64'({in_ready, out_valid}), 64'(2));
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) idx++;
      start_dump = dump_mid && guard == 2;
      in_valid = (idx < n) && (!rnd_valid || $urandom_range(0, 2) != 0);
      in_data  = (idx < n) ? d[idx] : '0;
    end
    in_valid = 1'b0; start_dump = 1'b0;
    if (idx < n) begin
      check(1'b0, "fill_timeout", 64'(idx), 64'(n));
      wq.delete();
    end
    wait_done();
  endtask

  // Dump: mode 0 ready always, 1 ready pattern 1,0,1,1,1, 2 random ready.
  task automatic run_dump(input int cnt, input int mode);
    int n, idx, guard, k;
    bit hs;
    bit pat [5];
    xfer_t r;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    n = (cnt > int'(DEPTH)) ? int'(DEPTH) : cnt;
    for (int i = 0; i < n; i++) begin
      r.adr  = AW'(i % int'(DEPTH));
      r.data = model[i % int'(DEPTH)];
      dq.push_back(r);
    end
    exp_done++;
    @(posedge clk); #1;
    start_dump = 1'b1; count = CW'(cnt);
    @(posedge clk); #1;
    start_dump = 1'b0;
    idx = 0; guard = 0; k = 0;
    out_ready = (mode == 1) ? pat[0] : (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      guard++; k++;
      if (hs) idx++;
      out_ready = (mode == 1) ? ((k < 5) ? pat[k] : 1'b1)
                : (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    out_ready = 1'b0;
    if (idx < n) begin
      check(1'b0, "dump_timeout", 64'(idx), 64'(n));
      dq.delete();
    end
    wait_done();
  endtask

  initial begin
    xfer_t w;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // Reset state, both while reset is held and just after release.
    repeat (2) @(negedge clk);
    check(!busy && !done && !in_ready && !out_valid && !ram_we, "reset_outputs",
          64'({busy, done, in_ready, out_valid, ram_we}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check(!busy && !done, "post_reset_idle", 64'({busy, done}), 64'(0));

    run_fill(4, 1'b1, 1'b0, 1'b0, 1'b0);     // 0xA0..0xA3 at adr 0..3
    run_dump(4, 1);                          // stalled dump of the same words
    run_fill(0, 1'b0, 1'b0, 1'b0, 1'b0);     // count 0: done only
    run_dump(0, 0);
    run_fill(64, 1'b0, 1'b1, 1'b0, 1'b0);    // full depth, ptr wraps
    run_fill(100, 1'b0, 1'b0, 1'b0, 1'b0);   // clamped to 64
    run_dump(64, 2);
    run_fill(8, 1'b0, 1'b0, 1'b1, 1'b0);     // start_fill and start_dump together
    run_fill(10, 1'b0, 1'b0, 1'b0, 1'b1);    // start_dump while busy is ignored
    run_dump(10, 0);

    // Reset two writes into a FILL: the reset cycle must not write, and no done follows.
    for (int i = 0; i < 2; i++) begin
      w.adr = AW'(i); w.data = DW'(32'h5500 + i);
      wq.push_back(w);
      model[i] = w.data;
    end
    @(posedge clk); #1;
    start_fill = 1'b1; count = CW'(8);
    @(posedge clk); #1;
    start_fill = 1'b0; in_valid = 1'b1; in_data = DW'(32'h5500);
    @(posedge clk); #1;
    in_data = DW'(32'h5501);
    @(posedge clk); #1;
    reset = 1'b1; in_data = DW'(32'h5502);
    @(negedge clk);
    check(!ram_we && !in_ready, "no_write_in_reset", 64'({ram_we, in_ready}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check(!busy && wq.size() == 0, "reset_aborts_fill", 64'({busy, 7'(wq.size())}), 64'(0));
    repeat (2) @(negedge clk);
    run_dump(4, 0);

`ifdef MEM_SEQUENCER_CLEAR_EN
    // Clear beats fill and ignores count; every word then reads back 0.
    for (int i = 0; i < int'(DEPTH); i++) begin
      w.adr = AW'(i); w.data = '0;
      wq.push_back(w);
      model[i] = '0;
    end
    exp_done++;
    @(posedge clk); #1;
    start_clear = 1'b1; start_fill = 1'b1; count = CW'(5);
    @(posedge clk); #1;
    start_clear = 1'b0; start_fill = 1'b0;
    for (int g = 0; g < 200 && wq.size() > 0; g++) begin
      @(negedge clk); #1;
    end
    check(wq.size() == 0, "clear_writes", 64'(wq.size()), 64'(0));
    wait_done();
    run_dump(64, 0);
`else
    // Without the clear feature start_clear does nothing.
    @(posedge clk); #1;
    start_clear = 1'b1; count = CW'(4);
    @(posedge clk); #1;
    start_clear = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check(!busy && !ram_we, "clear_ignored", 64'({busy, ram_we}), 64'(0));
    end
`endif

    // Random mix of fills and dumps against the array model.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 0)
        run_fill(int'($urandom_range(0, 80)), 1'b0, 1'b1, 1'b0, 1'b0);
      else
        run_dump(int'($urandom_range(0, 80)), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
